// File: rtl/jtpang_objdma_if.sv
// Z80 bus / VRAM port bundle between the object DMA master and the tile/VRAM block.
// The master requests the bus, drives the object-area address and takes back the read data.
interface jtpang_objdma_if #(
  parameter int DW = 8,
  parameter int AW = 9
);
  logic          busrq_n;
  logic          busak_n;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] vram_dout;

  modport master (
    output busrq_n,
    output dma_addr,
    input  busak_n,
    input  vram_dout
  );

  modport slave (
    input  busrq_n,
    input  dma_addr,
    output busak_n,
    output vram_dout
  );
endinterface

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: takes the Z80 bus and copies the 512-byte VRAM object area into a private
// buffer for the renderer. Optional JTPANG_DMA_VBL_EN: a falling LVBL edge also requests a copy.
module jtpang_objdma #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            dma_go,
  input  logic            LVBL,
  jtpang_objdma_if.master bus,
  input  logic [AW-1:0]   obj_addr,
  output logic [DW-1:0]   obj_data,
  output logic            dma_busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COPY,
    DRAIN,
    RELEASE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] dma_addr;
  logic [AW-1:0] wa;
  logic          we_d;
  logic          pend;
  logic          step;
  logic          last;
  logic          vbl_go;
  logic [DW-1:0] obj_buf [0:(1<<AW)-1];

  assign step         = cen & ~bus.busak_n;
  assign last         = &dma_addr;
  assign dma_busy     = (state != IDLE);
  assign bus.dma_addr = dma_addr;
  assign bus.busrq_n  = !((state == REQ) || (state == COPY) || (state == DRAIN));

`ifdef JTPANG_DMA_VBL_EN
  // A VBL edge only raises the pending flag, so it starts one clock later than dma_go.
  logic lvbl_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvbl_l <= 1'b1;
    end else begin
      lvbl_l <= LVBL;
    end
  end

  assign vbl_go = lvbl_l & ~LVBL;
`else
  logic unused_lvbl;

  assign unused_lvbl = LVBL;
  assign vbl_go      = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (dma_go || pend) next_state = REQ;
      REQ:     if (!bus.busak_n)   next_state = COPY;
      COPY:    if (step && last)   next_state = DRAIN;
      DRAIN:                       next_state = RELEASE;
      RELEASE: if (bus.busak_n)    next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // The write lags the step by one clock to line up with the synchronous VRAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dma_addr <= '0;
      wa       <= '0;
      we_d     <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state <= next_state;
      we_d  <= 1'b0;
      if (state == REQ) begin
        dma_addr <= '0;
      end
      if ((state == COPY) && step) begin
        dma_addr <= dma_addr + 1'b1;
        wa       <= dma_addr;
        we_d     <= 1'b1;
      end
      if ((state == IDLE) && (next_state == REQ)) begin
        pend <= 1'b0;
      end else if ((dma_go && dma_busy) || vbl_go) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_d) begin
      obj_buf[wa] <= bus.vram_dout;
    end
  end

  always_ff @(posedge clk) begin
    obj_data <= obj_buf[obj_addr];
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: a CPU model acknowledges the bus 3 clocks late, a VRAM model serves
// the object area, and buffer read-backs are checked through an expected-value queue.
module tb_jtpang_objdma;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int N  = 512;

  typedef struct {
    int          addr;
    logic [7:0]  data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen;
  logic          dma_go = 1'b0;
  logic          LVBL = 1'b1;
  logic [AW-1:0] obj_addr = '0;
  logic [DW-1:0] obj_data;
  logic          dma_busy;

  int errors = 0;
  int checks = 0;

  jtpang_objdma_if #(.DW(DW), .AW(AW)) bus ();

  jtpang_objdma #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .dma_go   (dma_go),
    .LVBL     (LVBL),
    .bus      (bus.master),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .dma_busy (dma_busy)
  );

  always #5 clk = ~clk;

  // CPU answers busrq_n after 3 clocks; stall forces the bus away mid-copy
  logic [2:0] ak_pipe = 3'b111;
  logic       stall = 1'b0;
  always @(posedge clk) ak_pipe <= {ak_pipe[1:0], bus.busrq_n};
  assign bus.busak_n = stall | ak_pipe[2];

  logic [7:0] vmem [N];
  always @(posedge clk) bus.vram_dout <= vmem[bus.dma_addr];

  logic [1:0] ph = 2'd0;
  logic       sparse = 1'b0;
  always @(posedge clk) ph <= ph + 2'd1;
  assign cen = sparse ? (ph == 2'd0) : 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] vdata(input int a, input logic [7:0] k, input bit mix);
    logic [31:0] av;
    av = a;
    return av[7:0] ^ k ^ ((mix && av[8]) ? 8'h80 : 8'h00);
  endfunction

  task automatic loadVram(input logic [7:0] k, input bit mix);
    for (int a = 0; a < N; a++) vmem[a] = vdata(a, k, mix);
  endtask

  // Scoreboard: expected read data queued by checkBuffer, compared one clock later
  rd_t  exp_q[$];
  logic rd_v = 1'b0;
  logic rd_v_d = 1'b0;
  always @(posedge clk) rd_v_d <= rd_v;

  always @(negedge clk) begin
    rd_t e;
    if (rd_v_d) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("obj_data[%0d]", e.addr), {24'd0, obj_data}, {24'd0, e.data});
      end
    end
  end

  // Address sweep and bus-request monitor
  logic [AW-1:0] seen_addr = '0;
  int            steps = 0;
  logic          prev_rq = 1'b1;
  int            rq_falls = 0;
  always @(negedge clk) begin
    logic [AW-1:0] want;
    if (rst) begin
      seen_addr = '0;
      steps     = 0;
    end else if (bus.dma_addr !== seen_addr) begin
      want = AW'(steps + 1);
      checkOutput("dma_addr sweep", {23'd0, bus.dma_addr}, {23'd0, want});
      steps++;
      seen_addr = bus.dma_addr;
    end
    if (!bus.busrq_n && prev_rq) rq_falls++;
    prev_rq = bus.busrq_n;
  end

  task automatic checkBuffer(input int lo, input int hi, input logic [7:0] k, input bit mix);
    for (int a = lo; a <= hi; a++) begin
      @(posedge clk); #1;
      obj_addr = AW'(a);
      rd_v     = 1'b1;
      exp_q.push_back('{addr: a, data: vdata(a, k, mix)});
    end
    @(posedge clk); #1;
    rd_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", exp_q.size(), 0);
  endtask

  // Pulse dma_go for one clock and check the 1-clock request latency
  task automatic applyStimulus();
    dma_go = 1'b1;
    @(negedge clk);
    checkOutput("busrq_n before go edge", bus.busrq_n, 1);
    @(posedge clk); #1;
    dma_go = 1'b0;
    @(negedge clk);
    checkOutput("go to busrq_n latency", bus.busrq_n, 0);
    checkOutput("dma_busy after go", dma_busy, 1);
  endtask

  task automatic pulseGo();
    dma_go = 1'b1;
    @(posedge clk); #1;
    dma_go = 1'b0;
  endtask

  task automatic waitAddr(input int a, input string name);
    for (int n = 0; n < 4000; n++) begin
      if (bus.dma_addr == AW'(a)) return;
      @(posedge clk); #1;
    end
    checkOutput({name, " addr timeout"}, 1, 0);
  endtask

  task automatic waitIdle(input int bound, input string name, output int lowboth);
    int n;
    lowboth = 0;
    for (n = 0; n < bound; n++) begin
      @(negedge clk);
      if (!bus.busrq_n && !bus.busak_n) lowboth++;
      if (!dma_busy) break;
    end
    if (n == bound) checkOutput({name, " idle timeout"}, 1, 0);
    checkOutput({name, " busrq_n released"}, bus.busrq_n, 1);
    checkOutput({name, " busak_n at idle"}, bus.busak_n, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    int f0;
    int both;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busrq_n", bus.busrq_n, 1);
    checkOutput("reset dma_addr", {23'd0, bus.dma_addr}, 0);
    checkOutput("reset dma_busy", dma_busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic copy");
    loadVram(8'h5A, 1'b0);
    s0 = steps;
    applyStimulus();
    waitIdle(2000, "basic", both);
    checkOutput("basic copy+ack+drain clocks", both, 514);
    checkOutput("basic step count", steps - s0, 512);
    checkBuffer(0, N - 1, 8'h5A, 1'b0);

    $display("[TB] sparse cen");
    loadVram(8'hA5, 1'b1);
    sparse = 1'b1;
    while (ph != 2'd0) begin
      @(posedge clk); #1;
    end
    s0 = steps;
    applyStimulus();
    waitIdle(3000, "sparse", both);
    checkOutput("sparse copy+ack+drain clocks", both, 2048 + 2);
    checkOutput("sparse step count", steps - s0, 512);
    sparse = 1'b0;
    checkBuffer(0, N - 1, 8'hA5, 1'b1);

    $display("[TB] stall");
    loadVram(8'h3C, 1'b1);
    s0 = steps;
    applyStimulus();
    waitAddr(100, "stall");
    stall = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall dma_addr hold", {23'd0, bus.dma_addr}, 100);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    waitIdle(2000, "stall", both);
    checkOutput("stall step count", steps - s0, 512);
    checkBuffer(0, N - 1, 8'h3C, 1'b1);

    $display("[TB] retrigger");
    loadVram(8'hC3, 1'b1);
    s0 = steps;
    f0 = rq_falls;
    applyStimulus();
    waitAddr(50, "retrig 50");
    pulseGo();
    waitAddr(200, "retrig 200");
    pulseGo();
    waitAddr(511, "retrig 511");
    pulseGo();
    repeat (1300) @(negedge clk);
    checkOutput("retrigger transfer count", rq_falls - f0, 2);
    checkOutput("retrigger step count", steps - s0, 1024);
    checkOutput("retrigger idle at end", dma_busy, 0);
    checkOutput("retrigger busrq_n at end", bus.busrq_n, 1);
    @(posedge clk); #1;
    checkBuffer(0, N - 1, 8'hC3, 1'b1);

    $display("[TB] reset mid-copy");
    loadVram(8'h0F, 1'b0);
    applyStimulus();
    waitAddr(300, "midreset");
    rst = 1'b1;
    #1;
    checkOutput("midreset busrq_n", bus.busrq_n, 1);
    checkOutput("midreset dma_addr", {23'd0, bus.dma_addr}, 0);
    checkOutput("midreset dma_busy", dma_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midreset stays idle", dma_busy, 0);
    checkBuffer(0, 298, 8'h0F, 1'b0);
    checkBuffer(300, N - 1, 8'hC3, 1'b1);

    $display("[TB] vbl trigger");
    loadVram(8'h96, 1'b1);
    f0 = rq_falls;
    LVBL = 1'b0;
`ifdef JTPANG_DMA_VBL_EN
    @(negedge clk);
    checkOutput("vbl busrq_n before edge", bus.busrq_n, 1);
    @(negedge clk);
    checkOutput("vbl busrq_n 1 clock after", bus.busrq_n, 1);
    @(negedge clk);
    checkOutput("vbl busrq_n 2 clocks after", bus.busrq_n, 0);
    waitIdle(2000, "vbl", both);
    checkOutput("vbl transfer count", rq_falls - f0, 1);
    checkBuffer(0, N - 1, 8'h96, 1'b1);
`else
    repeat (20) @(negedge clk);
    checkOutput("vbl ignored transfer count", rq_falls - f0, 0);
    checkOutput("vbl ignored dma_busy", dma_busy, 0);
`endif
    LVBL = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
